// File: rtl/sub_bytes_seq_if.sv
// Handshake bundle for the forward SubBytes engine: input state channel and
// held result channel. The slave modport is the engine side.
interface sub_bytes_seq_if;
   logic         inValid;
   logic         inReady;
   logic [127:0] prevState;
   logic         outValid;
   logic         outReady;
   logic [127:0] nextState;

   modport master (
      output inValid,
      output prevState,
      output outReady,
      input  inReady,
      input  outValid,
      input  nextState
   );

   modport slave (
      input  inValid,
      input  prevState,
      input  outReady,
      output inReady,
      output outValid,
      output nextState
   );
endinterface

// File: rtl/sub_bytes_seq.sv
// Iterative AES forward SubBytes: LANES shared S-boxes walk the 16-byte state
// MSB-first, one chunk per cycle, and hold the result until it is taken.
module sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   sub_bytes_seq_if.slave  bus,
   output logic            busy
);

   localparam int N  = 16 / LANES;
   localparam int CW = 8 * LANES;
   localparam logic [3:0] CNT_LAST = 4'(N - 1);

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_illegal
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   // FIPS-197 forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      sbox = SBOX_TBL[(11'd2047 - {x, 3'b000}) -: 8];
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] work_q, work_d;
   logic         out_valid_q, out_valid_d;
   logic         busy_q, busy_d;
   logic         in_ready_s;
   logic         load_s;
   logic [127:0] aligned_s;
   logic [7:0]   lane_out_s [LANES];

   // Shared S-box lanes fed from the chunk selected by the counter.
   always_comb begin
      aligned_s = work_q << (int'(cnt_q) * CW);
      for (int l = 0; l < LANES; l++) begin
         lane_out_s[l] = sbox(aligned_s[127 - 8*l -: 8]);
      end
   end

   // Next-state, working register update and output decode.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.outReady);
      load_s     = bus.inValid && in_ready_s;

      if (load_s) begin
         work_d  = bus.prevState;
         cnt_d   = 4'd0;
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               for (int i = 0; i < 16; i++) begin
                  if (4'(i / LANES) == cnt_q) begin
                     work_d[127 - 8*i -: 8] = lane_out_s[i % LANES];
                  end else begin
                     work_d[127 - 8*i -: 8] = work_q[127 - 8*i -: 8];
                  end
               end
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               if (bus.outReady) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d == ST_RUN);
   end

   // State, counter, working register and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         work_q      <= 128'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.inReady   = in_ready_s;
   assign bus.outValid  = out_valid_q;
   assign bus.nextState = work_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at LANES = 1, 4 and 16, checked against a
// GF(2^8) inverse-plus-affine S-box model built at time zero.
module tb_sub_bytes_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy1, busy4, busy16;

   always #5 clk = ~clk;

   sub_bytes_seq_if b1 ();
   sub_bytes_seq_if b4 ();
   sub_bytes_seq_if b16 ();

   sub_bytes_seq #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1),  .busy(busy1));
   sub_bytes_seq #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4),  .busy(busy4));
   sub_bytes_seq #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16), .busy(busy16));

   typedef struct packed {
      logic         busy;
      logic         in_ready;
      logic         out_valid;
      logic [127:0] ns;
   } obs_t;

   int checks = 0;
   int errors = 0;
   logic [7:0] fwd_tbl [256];
   logic [7:0] inv_tbl [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      repeat (254) r = gmul(r, a);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_model(input logic [127:0] s);
      logic [127:0] r;
      r = 128'd0;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = fwd_tbl[s[127 - 8*i -: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_model(input logic [127:0] s);
      logic [127:0] r;
      r = 128'd0;
      for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tbl[s[127 - 8*i -: 8]];
      return r;
   endfunction

   function automatic obs_t snap(input int w);
      obs_t o;
      o = '0;
      case (w)
         1:       o = {busy1, b1.inReady, b1.outValid, b1.nextState};
         4:       o = {busy4, b4.inReady, b4.outValid, b4.nextState};
         16:      o = {busy16, b16.inReady, b16.outValid, b16.nextState};
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic drive(input int w, input logic v, input logic [127:0] s, input logic r);
      case (w)
         1:       begin b1.inValid = v;  b1.prevState = s;  b1.outReady = r;  end
         4:       begin b4.inValid = v;  b4.prevState = s;  b4.outReady = r;  end
         16:      begin b16.inValid = v; b16.prevState = s; b16.outReady = r; end
         default: ;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full transfer: accept, wait for outValid, check, then hand the result off.
   task automatic xfer(input int w, input logic [127:0] st, input string tag, output logic [127:0] res);
      obs_t o;
      int lat;
      int busy_cnt;
      o = snap(w);
      chk({tag, " ready"}, 128'(o.in_ready), 128'd1);
      drive(w, 1'b1, st, 1'b0);
      tick();
      drive(w, 1'b0, rnd128(), 1'b0);
      o = snap(w);
      busy_cnt = o.busy ? 1 : 0;
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         o = snap(w);
         if (o.out_valid) begin
            lat = c;
            break;
         end
         if (o.busy) busy_cnt++;
      end
      res = o.ns;
      chk({tag, " latency"}, 128'(lat), 128'(16 / w));
      chk({tag, " busy"}, 128'(busy_cnt), 128'(16 / w));
      chk({tag, " data"}, o.ns, sub_model(st));
      chk({tag, " inverse"}, inv_model(o.ns), st);
      drive(w, 1'b0, rnd128(), 1'b1);
      tick();
      o = snap(w);
      chk({tag, " drop"}, 128'(o.out_valid), 128'd0);
      drive(w, 1'b0, 128'd0, 1'b0);
   endtask

   initial begin
      obs_t o;
      logic [127:0] res;
      logic [127:0] st;
      logic [127:0] blk [8];
      int cyc;

      drive(1, 1'b0, 128'd0, 1'b0);
      drive(4, 1'b0, 128'd0, 1'b0);
      drive(16, 1'b0, 128'd0, 1'b0);
      for (int i = 0; i < 256; i++) fwd_tbl[i] = sbox_ref(8'(i));
      for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);

      // Reset with random stimulus on every port.
      drive(1, 1'($urandom), rnd128(), 1'($urandom));
      drive(4, 1'b1, rnd128(), 1'($urandom));
      drive(16, 1'($urandom), rnd128(), 1'($urandom));
      tick();
      tick();
      for (int k = 0; k < 3; k++) begin
         o = snap(k == 0 ? 1 : (k == 1 ? 4 : 16));
         chk("rst nextState", o.ns, 128'd0);
         chk("rst flags", {125'd0, o.busy, o.in_ready, o.out_valid}, 128'b010);
      end
      drive(1, 1'b0, rnd128(), 1'b0);
      drive(4, 1'b0, rnd128(), 1'b0);
      drive(16, 1'b0, rnd128(), 1'b0);
      rst_n = 1'b1;
      repeat (5) tick();
      o = snap(4);
      chk("idle nextState", o.ns, 128'd0);
      chk("idle flags", {125'd0, o.busy, o.in_ready, o.out_valid}, 128'b010);

      // FIPS-197 round-1 SubBytes vector.
      xfer(4, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips", res);
      chk("fips literal", res, 128'hd42711aee0bf98f1b8b45de51e415230);

      // All-zero and all-FF blocks at the extremes of LANES.
      xfer(1, 128'd0, "zero l1", res);
      chk("zero l1 literal", res, {16{8'h63}});
      xfer(16, {16{8'hff}}, "ff l16", res);
      chk("ff l16 literal", res, {16{8'h16}});

      // Exhaustive byte coverage on LANES=1 and LANES=16.
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = 8'(j*16 + i);
         xfer(1, st, $sformatf("exh l1 %0d", j), res);
         xfer(16, st, $sformatf("exh l16 %0d", j), res);
      end

      // Backpressure: hold the result for 10 cycles while inValid pulses.
      st = 128'h00112233445566778899aabbccddeeff;
      drive(4, 1'b1, st, 1'b0);
      tick();
      drive(4, 1'b0, rnd128(), 1'b0);
      cyc = 0;
      do begin
         tick();
         cyc++;
         o = snap(4);
      end while (!o.out_valid && cyc < 40);
      chk("bp latency", 128'(cyc), 128'd4);
      for (int c = 0; c < 10; c++) begin
         drive(4, 1'(c % 2), rnd128(), 1'b0);
         #1;
         o = snap(4);
         chk("bp inReady", 128'(o.in_ready), 128'd0);
         tick();
         o = snap(4);
         chk("bp outValid", 128'(o.out_valid), 128'd1);
         chk("bp data", o.ns, 128'h638293c31bfc33f5c4eeacea4bc12816);
      end
      drive(4, 1'b0, rnd128(), 1'b1);
      tick();
      o = snap(4);
      chk("bp release", {125'd0, o.busy, o.in_ready, o.out_valid}, 128'b010);
      drive(4, 1'b0, 128'd0, 1'b0);

      // Back-to-back with inValid and outReady held high.
      for (int k = 0; k < 8; k++) blk[k] = rnd128();
      drive(4, 1'b1, blk[0], 1'b1);
      for (int k = 0; k < 8; k++) begin
         cyc = 0;
         do begin
            tick();
            cyc++;
            o = snap(4);
         end while (!o.out_valid && cyc < 40);
         chk($sformatf("b2b period %0d", k), 128'(cyc), 128'd5);
         chk($sformatf("b2b data %0d", k), o.ns, sub_model(blk[k]));
         if (k < 7) drive(4, 1'b1, blk[k + 1], 1'b1);
         else drive(4, 1'b0, rnd128(), 1'b1);
      end
      tick();
      o = snap(4);
      chk("b2b end", {125'd0, o.busy, o.in_ready, o.out_valid}, 128'b010);
      drive(4, 1'b0, 128'd0, 1'b0);

      // Reset asserted while cnt=2 discards the block.
      drive(4, 1'b1, rnd128(), 1'b0);
      tick();
      drive(4, 1'b0, rnd128(), 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      o = snap(4);
      chk("midrst nextState", o.ns, 128'd0);
      chk("midrst flags", {125'd0, o.busy, o.in_ready, o.out_valid}, 128'b010);
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         o = snap(4);
         chk("midrst no valid", 128'(o.out_valid), 128'd0);
      end
      xfer(4, 128'hffeeddccbbaa99887766554433221100, "after rst", res);
      chk("after rst literal", res, 128'h1628c14beaaceec4f533fc1bc3938263);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
